// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word memory controller with byte enables, range check and one-shot request/response FSM
// Optional macro DMEM_INIT_EN: after reset, sweep word i <= i before accepting requests.

module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef DMEM_INIT_EN
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;
  localparam state_t RST_STATE = INIT;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]     be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;

  // Gating with rst keeps the request side closed on the abort edge itself.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef DMEM_INIT_EN
  logic [IDX_W-1:0] init_cnt;
  logic             init_last;

  assign init_last = (init_cnt == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
`ifdef DMEM_INIT_EN
      INIT:    if (init_last) state_n = IDLE;
`endif
      IDLE:    if (accept) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = RST_STATE;
    endcase
  end

  // The range check is resolved at accept so ACCESS only needs the short index.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      idx_q   <= req_addr[IDX_W-1:0];
      wdata_q <= req_wdata;
      be_q    <= req_be;
      oor_q   <= ({1'b0, req_addr} >= DEPTH_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      err_q   <= oor_q;
      rdata_q <= (!write_q && !oor_q) ? mem[idx_q] : '0;
    end
  end

  // No reset on the array: contents survive rst, and rst blocks any commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef DMEM_INIT_EN
      if (state == INIT) begin
        mem[init_cnt] <= DATA_WIDTH'(init_cnt);
      end
`endif
      if (state == ACCESS && write_q && !oor_q) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (be_q[k]) begin
            mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

endmodule
